// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter:
//   - state_t : FSM state encoding (IDLE -> ACCESS -> ACK -> IDLE)
//   - PORT0/PORT1 : requester index values
//   - tie_winner() : tie-break helper used by the winner picker
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Both ports requesting: fixed priority favours port 0, otherwise the
    // port that was not granted last time wins.
    function automatic logic tie_winner(input logic prio_fixed, input logic last_grant);
        logic win;
        if (prio_fixed) begin
            win = PORT0;
        end else begin
            win = ~last_grant;
        end
        return win;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way winner select.
// Ports:
//   i_req0, i_req1   request lines of port 0 / port 1
//   i_last_grant     index of the port granted most recently
//   o_valid          at least one request present
//   o_idx            index of the winning port (PORT0 when nothing requests)
// Parameter PRIO_FIXED: 0 = round-robin on ties, 1 = port 0 wins ties.
// -----------------------------------------------------------------------------
module rr_pick2
    import dmem_arbiter_pkg::*;
#(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_idx
);

    // Winner selection; single requester always wins outright.
    always_comb begin
        o_valid = i_req0 | i_req1;
        o_idx   = PORT0;
        if (i_req0 && i_req1) begin
            o_idx = tie_winner(PRIO_FIXED, i_last_grant);
        end else if (i_req1) begin
            o_idx = PORT1;
        end else begin
            o_idx = PORT0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between port 0 (pipeline MEM stage) and
// port 1 (debug/DMA loader). One request is latched at a time; the memory
// strobes are driven for exactly one cycle, then the winner gets a one-cycle
// ack together with its read data. Every output comes from a flop.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pX_req/pX_we/pX_addr/pX_wdata  request side of port X (held until ack)
//   pX_ack/pX_rdata             completion pulse and read data of port X
//   mem_we/mem_re/mem_addr/mem_wdata  memory control pins
//   mem_rdata                   memory read data
//   busy                        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_winner;
    logic                r_last_grant;
    logic                r_mem_we;
    logic                r_mem_re;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_p0_ack;
    logic                r_p1_ack;
    logic [DATA_W-1:0]   r_p0_rdata;
    logic [DATA_W-1:0]   r_p1_rdata;
    logic                r_busy;
    logic                w_pick_valid;
    logic                w_pick_idx;

    rr_pick2 #(
        .PRIO_FIXED (PRIO_FIXED)
    ) u_pick (
        .i_req0       (p0_req),
        .i_req1       (p1_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_idx        (w_pick_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: fixed three-step cycle, IDLE waits for a request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = ACCESS;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACCESS:  w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output registers: memory pins, acks, read data, grant history, busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winner     <= PORT0;
            r_last_grant <= PORT1;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_p0_ack <= 1'b0;
                    r_p1_ack <= 1'b0;
                    if (w_pick_valid) begin
                        // The winner's address/data are sampled only now, so a
                        // port that lost earlier is served with its current values.
                        r_winner <= w_pick_idx;
                        if (w_pick_idx == PORT1) begin
                            r_mem_addr  <= p1_addr;
                            r_mem_wdata <= p1_wdata;
                            r_mem_we    <= p1_we;
                            r_mem_re    <= ~p1_we;
                        end else begin
                            r_mem_addr  <= p0_addr;
                            r_mem_wdata <= p0_wdata;
                            r_mem_we    <= p0_we;
                            r_mem_re    <= ~p0_we;
                        end
                    end else begin
                        r_mem_we <= 1'b0;
                        r_mem_re <= 1'b0;
                    end
                end
                ACCESS: begin
                    r_mem_we <= 1'b0;
                    r_mem_re <= 1'b0;
                    if (r_mem_re) begin
                        if (r_winner == PORT1) begin
                            r_p1_rdata <= mem_rdata;
                        end else begin
                            r_p0_rdata <= mem_rdata;
                        end
                    end else begin
                        r_p0_rdata <= r_p0_rdata;
                    end
                    // The ack fires even if the requester dropped req mid-access.
                    r_p0_ack     <= (r_winner == PORT0);
                    r_p1_ack     <= (r_winner == PORT1);
                    r_last_grant <= r_winner;
                end
                ACK: begin
                    r_p0_ack <= 1'b0;
                    r_p1_ack <= 1'b0;
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_mem_re <= 1'b0;
                    r_p0_ack <= 1'b0;
                    r_p1_ack <= 1'b0;
                end
            endcase
            r_busy <= (w_next_state != IDLE);
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign p0_ack    = r_p0_ack;
    assign p1_ack    = r_p1_ack;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       p0_req, p0_we, p1_req, p1_we;
    logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic       p0_ack, p1_ack;
    logic [7:0] p0_rdata, p1_rdata;
    logic       mem_we, mem_re, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    // Second instance with fixed priority
    logic       q0_req, q1_req;
    logic       q0_ack, q1_ack;
    logic [7:0] q0_rdata, q1_rdata;
    logic       q_mem_we, q_mem_re, q_busy;
    logic [7:0] q_mem_addr, q_mem_wdata;

    logic [7:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    int q0_acks;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_FIXED(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_FIXED(1'b1)) dut_fix (
        .clk(clk), .rst_n(rst_n),
        .p0_req(q0_req), .p0_we(1'b0), .p0_addr(8'h01), .p0_wdata(8'h00),
        .p0_ack(q0_ack), .p0_rdata(q0_rdata),
        .p1_req(q1_req), .p1_we(1'b0), .p1_addr(8'h02), .p1_wdata(8'h00),
        .p1_ack(q1_ack), .p1_rdata(q1_rdata),
        .mem_we(q_mem_we), .mem_re(q_mem_re), .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata),
        .mem_rdata(8'h00), .busy(q_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exclusivity watch on every cycle outside reset
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk1("excl_strobes", mem_we & mem_re, 1'b0);
            chk1("excl_acks", p0_ack & p1_ack, 1'b0);
        end
    end

    initial begin
        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
        q0_req = 1'b0; q1_req = 1'b0;
        tick(); tick();
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_mem_re", mem_re, 1'b0);
        chk8("rst_mem_addr", mem_addr, 8'h00);
        chk8("rst_p0_rdata", p0_rdata, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_p0_ack", p0_ack, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1. p0 write 10<-A5, then read back
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h10; p0_wdata = 8'hA5;
        tick();
        chk1("t1w_mem_we", mem_we, 1'b1);
        chk1("t1w_mem_re", mem_re, 1'b0);
        chk8("t1w_addr", mem_addr, 8'h10);
        chk8("t1w_wdata", mem_wdata, 8'hA5);
        chk1("t1w_busy", busy, 1'b1);
        chk1("t1w_ack_early", p0_ack, 1'b0);
        tick();
        chk1("t1w_mem_we_off", mem_we, 1'b0);
        chk1("t1w_ack", p0_ack, 1'b1);
        chk8("t1w_memcell", mem[8'h10], 8'hA5);
        p0_req = 1'b0;
        tick();
        chk1("t1w_ack_off", p0_ack, 1'b0);
        chk1("t1w_idle", busy, 1'b0);
        chk8("t1w_addr_hold", mem_addr, 8'h10);
        p0_req = 1'b1; p0_we = 1'b0;
        tick();
        chk1("t1r_mem_re", mem_re, 1'b1);
        chk1("t1r_mem_we", mem_we, 1'b0);
        tick();
        chk1("t1r_ack", p0_ack, 1'b1);
        chk8("t1r_rdata", p0_rdata, 8'hA5);
        p0_req = 1'b0;
        tick();

        // 2. Round-robin from a fresh reset: p0 reads 10, p1 writes 30<-5A
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h30; p1_wdata = 8'h5A;
        tick();
        chk1("t2a_re", mem_re, 1'b1);
        chk8("t2a_addr", mem_addr, 8'h10);
        tick();
        chk1("t2a_p0_ack", p0_ack, 1'b1);
        chk1("t2a_p1_ack", p1_ack, 1'b0);
        chk8("t2a_rdata", p0_rdata, 8'hA5);
        tick();
        chk1("t2a_idle", busy, 1'b0);
        chk1("t2a_ack_off", p0_ack, 1'b0);
        tick();
        chk1("t2b_we", mem_we, 1'b1);
        chk8("t2b_addr", mem_addr, 8'h30);
        tick();
        chk1("t2b_p1_ack", p1_ack, 1'b1);
        chk1("t2b_p0_ack", p0_ack, 1'b0);
        chk8("t2b_memcell", mem[8'h30], 8'h5A);
        tick();
        chk1("t2b_idle", busy, 1'b0);
        tick();
        chk1("t2c_re", mem_re, 1'b1);
        chk8("t2c_addr", mem_addr, 8'h10);
        tick();
        chk1("t2c_p0_ack", p0_ack, 1'b1);
        chk1("t2c_p1_ack", p1_ack, 1'b0);
        p0_req = 1'b0; p1_req = 1'b0;
        tick();

        // 3. Fixed priority: port 1 starves while port 0 holds req
        q0_req = 1'b1; q1_req = 1'b1;
        q0_acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk1("t3_q1_starved", q1_ack, 1'b0);
            if (q0_ack === 1'b1) q0_acks++;
        end
        chk8("t3_q0_ack_count", 8'(q0_acks), 8'd4);
        q0_req = 1'b0;
        tick();
        tick();
        chk1("t3_q1_served", q1_ack, 1'b1);
        q1_req = 1'b0;
        tick();

        // 4. Preload FF<-3C through port 1, then port 1 reads it back
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'hFF; p1_wdata = 8'h3C;
        tick(); tick();
        chk1("t4_pre_ack", p1_ack, 1'b1);
        p1_req = 1'b0;
        tick();
        p1_req = 1'b1; p1_we = 1'b0;
        tick();
        chk1("t4_re", mem_re, 1'b1);
        chk1("t4_we", mem_we, 1'b0);
        chk8("t4_addr", mem_addr, 8'hFF);
        tick();
        chk1("t4_re_off", mem_re, 1'b0);
        chk1("t4_p1_ack", p1_ack, 1'b1);
        chk8("t4_p1_rdata", p1_rdata, 8'h3C);
        chk8("t4_p0_rdata", p0_rdata, 8'hA5);
        p1_req = 1'b0;
        tick();

        // 5. Reset asserted during ACCESS of a write
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h40; p0_wdata = 8'h77;
        tick();
        chk1("t5_we_before", mem_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("t5_we_async", mem_we, 1'b0);
        chk1("t5_busy_async", busy, 1'b0);
        chk8("t5_addr_async", mem_addr, 8'h00);
        p0_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk1("t5_no_ack", p0_ack, 1'b0);
        chk1("t5_idle", busy, 1'b0);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h41; p1_wdata = 8'h99;
        tick();
        chk1("t5_next_we", mem_we, 1'b1);
        chk8("t5_next_addr", mem_addr, 8'h41);
        tick();
        chk1("t5_next_ack", p1_ack, 1'b1);
        chk8("t5_next_cell", mem[8'h41], 8'h99);
        p1_req = 1'b0;
        tick();

        // 6. p0 read with req dropped during ACCESS
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h41;
        tick();
        chk1("t6_re", mem_re, 1'b1);
        p0_req = 1'b0;
        tick();
        chk1("t6_ack", p0_ack, 1'b1);
        chk8("t6_rdata", p0_rdata, 8'h99);
        tick();
        chk1("t6_ack_off", p0_ack, 1'b0);
        chk1("t6_idle", busy, 1'b0);
        tick();
        chk1("t6_stay_idle", busy, 1'b0);
        chk1("t6_no_reack", p0_ack, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
